// File: rtl/sim_cache_core.sv
// rtl/sim_cache_core.sv - unified direct-mapped write-through cache, two slave ports, one master; SIM_CACHE_STATS_EN adds hit/miss counters
module sim_cache_core #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_inst_address,
  input  logic              avs_inst_read,
  output logic              avs_inst_waitrequest,
  output logic [31:0]       avs_inst_readdata,
  output logic              avs_inst_readdatavalid,
  input  logic [ADDR_W-1:0] avs_data_address,
  input  logic              avs_data_read,
  input  logic              avs_data_write,
  input  logic [3:0]        avs_data_byteenable,
  input  logic [31:0]       avs_data_writedata,
  output logic              avs_data_waitrequest,
  output logic [31:0]       avs_data_readdata,
  output logic              avs_data_readdatavalid,
  output logic [ADDR_W-1:0] avm_mem_address,
  output logic              avm_mem_read,
  output logic              avm_mem_write,
  output logic [3:0]        avm_mem_byteenable,
  output logic [31:0]       avm_mem_writedata,
  input  logic              avm_mem_waitrequest,
  input  logic [31:0]       avm_mem_readdata,
  input  logic              avm_mem_readdatavalid
`ifdef SIM_CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_WTHRU  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              prio_data_q, prio_data_d;   // 1: data port wins a tie
  logic              port_data_q, port_data_d;   // request in flight came from the data port
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;               // refill word counter
  logic              pend_q, pend_d;             // refill read accepted, awaiting data
  logic [31:0]       inst_rdata_q, inst_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  logic [OFF_W-1:0]       req_off;
  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic [31:0]            cur_word;
  logic [31:0]            merged_word;
  logic                   grant_data, grant_inst;
  logic                   accept_data, accept_inst;
  logic                   arr_we;
  logic [IDX_W+OFF_W-1:0] arr_waddr;
  logic [31:0]            arr_wdata;
  logic                   fill_done;
  logic                   resp_load;
  logic [31:0]            resp_word;

  assign req_off  = addr_q[OFF_W+1:2];
  assign req_idx  = addr_q[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag  = addr_q[ADDR_W-1:OFF_W+IDX_W+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_word = data_q[{req_idx, req_off}];

  // Arbitration and port handshakes: only the granted port sees waitrequest low, and only in IDLE
  always_comb begin
    grant_data = (avs_data_read || avs_data_write) && (!avs_inst_read || prio_data_q);
    grant_inst = avs_inst_read && !grant_data;
    avs_data_waitrequest = !(reset_reset_n && (state_q == S_IDLE) && grant_data);
    avs_inst_waitrequest = !(reset_reset_n && (state_q == S_IDLE) && grant_inst);
    accept_data = grant_data && !avs_data_waitrequest;
    accept_inst = grant_inst && !avs_inst_waitrequest;
  end

  // Byte-lane merge of the pending write into the cached word
  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merged_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Transaction sequencing, array write controls and response capture
  always_comb begin
    state_d      = state_q;
    prio_data_d  = prio_data_q;
    port_data_d  = port_data_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    arr_we       = 1'b0;
    arr_waddr    = {req_idx, req_off};
    arr_wdata    = merged_word;
    fill_done    = 1'b0;
    resp_load    = 1'b0;
    resp_word    = cur_word;
    case (state_q)
      S_IDLE: begin
        if (accept_data || accept_inst) begin
          state_d     = S_LOOKUP;
          port_data_d = accept_data;
          prio_data_d = !accept_data;
          is_write_d  = accept_data && avs_data_write;
          addr_d      = accept_data ? avs_data_address : avs_inst_address;
          be_d        = avs_data_byteenable;
          wdata_d     = avs_data_writedata;
        end
      end
      S_LOOKUP: begin
        if (is_write_q) begin
          arr_we  = hit;
          state_d = S_WTHRU;
        end else if (hit) begin
          resp_load = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (!pend_q) begin
          if (!avm_mem_waitrequest) pend_d = 1'b1;
        end else if (avm_mem_readdatavalid) begin
          pend_d    = 1'b0;
          arr_we    = 1'b1;
          arr_waddr = {req_idx, cnt_q};
          arr_wdata = avm_mem_readdata;
          cnt_d     = cnt_q + OFF_W'(1);
          if (&cnt_q) begin
            fill_done = 1'b1;
            resp_load = 1'b1;
            // earlier words of the line are already in the array; the last one is still on the bus
            resp_word = (cnt_q == req_off) ? avm_mem_readdata : cur_word;
            state_d   = S_RESP;
          end
        end
      end
      S_WTHRU: begin
        if (!avm_mem_waitrequest) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (resp_load) begin
      if (port_data_q) data_rdata_d = resp_word;
      else             inst_rdata_d = resp_word;
    end
  end

  // Master command and slave response outputs decoded from the current state
  always_comb begin
    avm_mem_read           = (state_q == S_REFILL) && !pend_q;
    avm_mem_write          = (state_q == S_WTHRU);
    avm_mem_address        = (state_q == S_WTHRU) ? addr_q : {req_tag, req_idx, cnt_q, 2'b00};
    avm_mem_byteenable     = (state_q == S_WTHRU) ? be_q : 4'b1111;
    avm_mem_writedata      = wdata_q;
    avs_inst_readdatavalid = (state_q == S_RESP) && !is_write_q && !port_data_q;
    avs_data_readdatavalid = (state_q == S_RESP) && !is_write_q && port_data_q;
    avs_inst_readdata      = inst_rdata_q;
    avs_data_readdata      = data_rdata_q;
  end

  // Control and response registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q      <= S_IDLE;
      prio_data_q  <= 1'b1;
      port_data_q  <= 1'b1;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_data_q  <= prio_data_d;
      port_data_q  <= port_data_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Valid bits: cleared by reset, set once a whole line has been refilled
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) valid_q <= '0;
    else if (fill_done) valid_q[req_idx] <= 1'b1;
  end

  // Tag and data storage, unreset since valid bits gate every use
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && arr_we)    data_q[arr_waddr] <= arr_wdata;
    if (reset_reset_n && fill_done) tag_q[req_idx]    <= req_tag;
  end

`ifdef SIM_CACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  // Saturating counters of LOOKUP outcomes
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == S_LOOKUP) begin
      if (hit && (hits_q != '1))        hits_d   = hits_q + 32'd1;
      if (!hit && (misses_q != '1))     misses_d = misses_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_sim_cache_core.sv
// tb/tb_sim_cache_core.sv - directed-vector and random bench for sim_cache_core
module tb_sim_cache_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] avs_inst_address;
  logic        avs_inst_read;
  logic        avs_inst_waitrequest;
  logic [31:0] avs_inst_readdata;
  logic        avs_inst_readdatavalid;
  logic [31:0] avs_data_address;
  logic        avs_data_read;
  logic        avs_data_write;
  logic [3:0]  avs_data_byteenable;
  logic [31:0] avs_data_writedata;
  logic        avs_data_waitrequest;
  logic [31:0] avs_data_readdata;
  logic        avs_data_readdatavalid;
  logic [31:0] avm_mem_address;
  logic        avm_mem_read;
  logic        avm_mem_write;
  logic [3:0]  avm_mem_byteenable;
  logic [31:0] avm_mem_writedata;
  logic        mem_wait;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
`ifdef SIM_CACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  sim_cache_core dut (
    .clk_clk                (clk),
    .reset_reset_n          (rst_n),
    .avs_inst_address       (avs_inst_address),
    .avs_inst_read          (avs_inst_read),
    .avs_inst_waitrequest   (avs_inst_waitrequest),
    .avs_inst_readdata      (avs_inst_readdata),
    .avs_inst_readdatavalid (avs_inst_readdatavalid),
    .avs_data_address       (avs_data_address),
    .avs_data_read          (avs_data_read),
    .avs_data_write         (avs_data_write),
    .avs_data_byteenable    (avs_data_byteenable),
    .avs_data_writedata     (avs_data_writedata),
    .avs_data_waitrequest   (avs_data_waitrequest),
    .avs_data_readdata      (avs_data_readdata),
    .avs_data_readdatavalid (avs_data_readdatavalid),
    .avm_mem_address        (avm_mem_address),
    .avm_mem_read           (avm_mem_read),
    .avm_mem_write          (avm_mem_write),
    .avm_mem_byteenable     (avm_mem_byteenable),
    .avm_mem_writedata      (avm_mem_writedata),
    .avm_mem_waitrequest    (mem_wait),
    .avm_mem_readdata       (mem_rdata),
    .avm_mem_readdatavalid  (mem_rvalid)
`ifdef SIM_CACHE_STATS_EN
    ,
    .stat_hits              (stat_hits),
    .stat_misses            (stat_misses)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return (i >= 64) ? (32'hC0DE0000 | 32'(i)) : 32'h0;
  endfunction

  // backing memory: random stalls, one-cycle read latency, shares the reset
  logic [31:0] mem [1024];
  logic [31:0] model [1024];
  logic        mem_init_done = 1'b0;
  int          wr_cnt = 0;
  logic [31:0] rd_log [$];
  logic        inject;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_wait   <= 1'b0;
      mem_rdata  <= 32'h0;
    end else begin
      mem_wait   <= ($urandom_range(0, 3) == 0);
      mem_rvalid <= 1'b0;
      if (avm_mem_read && !mem_wait) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[avm_mem_address[11:2]];
        rd_log.push_back(avm_mem_address);
      end else if (inject) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= 32'hBADBAD00;
      end
      if (avm_mem_write && !mem_wait) begin
        for (int b = 0; b < 4; b++)
          if (avm_mem_byteenable[b]) mem[avm_mem_address[11:2]][8*b +: 8] <= avm_mem_writedata[8*b +: 8];
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  int  inst_rdv_cnt = 0, data_rdv_cnt = 0;
  time inst_rdv_t = 0, data_rdv_t = 0;
  always @(negedge clk) begin
    if (avs_inst_readdatavalid) begin inst_rdv_cnt <= inst_rdv_cnt + 1; inst_rdv_t <= $time; end
    if (avs_data_readdatavalid) begin data_rdv_cnt <= data_rdv_cnt + 1; data_rdv_t <= $time; end
  end

  int checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) model[a[11:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // one port transaction; lat counts falling edges from acceptance to readdatavalid
  task automatic port_op(input bit is_data, input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int n;
    bit acc, got;
    rd = '0; lat = -1; n = 0; acc = 0; got = 0;
    @(negedge clk);
    if (is_data) begin
      avs_data_address = addr; avs_data_read = !we; avs_data_write = we;
      avs_data_byteenable = be; avs_data_writedata = wd;
    end else begin
      avs_inst_address = addr; avs_inst_read = 1'b1;
    end
    while (!acc && n < 400) begin
      #1;
      if (is_data ? !avs_data_waitrequest : !avs_inst_waitrequest) acc = 1;
      else begin n++; @(negedge clk); end
    end
    @(posedge clk);
    #1;
    if (is_data) begin avs_data_read = 1'b0; avs_data_write = 1'b0; end
    else avs_inst_read = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr %h: not accepted within 400 cycles", addr);
    end else if (!we) begin
      lat = 0;
      while (!got && lat < 400) begin
        @(negedge clk);
        lat++;
        if (is_data ? avs_data_readdatavalid : avs_inst_readdatavalid) begin
          got = 1;
          rd = is_data ? avs_data_readdata : avs_inst_readdata;
        end
      end
      if (!got) begin
        checks++; errors++; lat = -1;
        $display("FAIL rdv_timeout addr %h: no readdatavalid within 400 cycles", addr);
      end else begin
        @(negedge clk);
        chk($sformatf("rdv_pulse_%h", addr), 32'(is_data ? avs_data_readdatavalid : avs_inst_readdatavalid), 0);
      end
    end
  endtask

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
    int          exp_reads;
    bit          exp_hit;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd_a, rd_b, a, wd;
    logic [3:0]  be;
    int lat, lat_a, lat_b, r0, w0, n, c0, c1;
    bit isd, we;

    vecs[0]  = '{0, 0, 32'h000, 4'hF, 32'h0,        32'h00000000, 4, 0};
    vecs[1]  = '{1, 1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[2]  = '{0, 0, 32'h010, 4'hF, 32'h0,        32'hDEADBEEF, 4, 0};
    vecs[3]  = '{1, 1, 32'h020, 4'h3, 32'h12345678, 32'h0,        0, 0};
    vecs[4]  = '{1, 0, 32'h020, 4'hF, 32'h0,        32'h00005678, 4, 0};
    vecs[5]  = '{1, 1, 32'h024, 4'hC, 32'hAABBCCDD, 32'h0,        0, 1};
    vecs[6]  = '{0, 0, 32'h024, 4'hF, 32'h0,        32'hAABB0000, 0, 1};
    vecs[7]  = '{1, 1, 32'h024, 4'h0, 32'h11223344, 32'h0,        0, 1};
    vecs[8]  = '{1, 0, 32'h024, 4'hF, 32'h0,        32'hAABB0000, 0, 1};
    vecs[9]  = '{1, 0, 32'h100, 4'hF, 32'h0,        32'hC0DE0040, 4, 0};
    vecs[10] = '{0, 0, 32'h000, 4'hF, 32'h0,        32'h00000000, 4, 0};
    vecs[11] = '{0, 0, 32'h00C, 4'hF, 32'h0,        32'h00000000, 0, 1};

    for (int i = 0; i < 1024; i++) model[i] = init_word(i);
    checks = 0; errors = 0; inject = 0;
    avs_inst_address = 0; avs_inst_read = 0;
    avs_data_address = 0; avs_data_read = 0; avs_data_write = 0;
    avs_data_byteenable = 0; avs_data_writedata = 0;
    rst_n = 0;

    // reset state, including a request held during reset
    avs_inst_read = 1;
    repeat (3) @(negedge clk);
    chk("rst_inst_wait_req", 32'(avs_inst_waitrequest), 1);
    avs_inst_read = 0;
    #1;
    chk("rst_inst_wait", 32'(avs_inst_waitrequest), 1);
    chk("rst_data_wait", 32'(avs_data_waitrequest), 1);
    chk("rst_rdv", {30'h0, avs_inst_readdatavalid, avs_data_readdatavalid}, 0);
    chk("rst_avm_cmd", {30'h0, avm_mem_read, avm_mem_write}, 0);
    chk("rst_inst_rdata", avs_inst_readdata, 0);
    chk("rst_data_rdata", avs_data_readdata, 0);
    @(negedge clk);
    rst_n = 1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      r0 = rd_log.size();
      w0 = wr_cnt;
      port_op(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, rd, lat);
      if (vecs[i].we) begin
        model_write(vecs[i].addr, vecs[i].be, vecs[i].wd);
        n = 0;
        while (wr_cnt == w0 && n < 100) begin @(negedge clk); n++; end
        chk($sformatf("v%0d_avm_writes", i), wr_cnt - w0, 1);
      end else begin
        chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp);
        if (vecs[i].exp_hit) chk($sformatf("v%0d_hit_latency", i), lat, 2);
      end
      chk($sformatf("v%0d_refill_reads", i), rd_log.size() - r0, vecs[i].exp_reads);
`ifdef SIM_CACHE_STATS_EN
      if (i == 0) begin
        chk("stat_misses_first", stat_misses, 1);
        chk("stat_hits_first", stat_hits, 0);
      end
`endif
    end
    if (rd_log.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("refill_addr_%0d", k), rd_log[k], 32'(4 * k));
    chk("mem_0x10", mem[4], 32'hDEADBEEF);
    chk("mem_0x20", mem[8], 32'h00005678);
    chk("mem_0x24", mem[9], 32'hAABB0000);

    // memory read data outside a refill must not disturb the cache
    @(negedge clk); inject = 1;
    @(negedge clk); inject = 0;
    repeat (2) @(negedge clk);
    port_op(0, 0, 32'h00C, 4'hF, 32'h0, rd, lat);
    chk("stray_rdata", rd, 32'h0);
    chk("stray_latency", lat, 2);

    // simultaneous requests; data served last, so the instruction port goes first
    port_op(1, 1, 32'h044, 4'hF, 32'h44444444, rd, lat);
    model_write(32'h044, 4'hF, 32'h44444444);
    c0 = inst_rdv_cnt; c1 = data_rdv_cnt;
    fork
      port_op(0, 0, 32'h004, 4'hF, 32'h0, rd_a, lat_a);
      port_op(1, 0, 32'h044, 4'hF, 32'h0, rd_b, lat_b);
    join
    repeat (4) @(negedge clk);
    chk("both_inst_rdata", rd_a, 32'h0);
    chk("both_data_rdata", rd_b, 32'h44444444);
    chk("both_inst_once", inst_rdv_cnt - c0, 1);
    chk("both_data_once", data_rdv_cnt - c1, 1);
    chk("both_inst_first", 32'(inst_rdv_t < data_rdv_t), 1);
    port_op(0, 0, 32'h004, 4'hF, 32'h0, rd, lat);
    chk("reread_rdata", rd, 32'h0);
    chk("reread_latency", lat, 2);

    // reset in the middle of a refill: no response, cache invalidated
    @(negedge clk);
    avs_data_address = 32'h200; avs_data_read = 1;
    n = 0;
    #1;
    while (avs_data_waitrequest && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    avs_data_read = 0;
    c1 = data_rdv_cnt;
    repeat (3) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("abort_no_response", data_rdv_cnt - c1, 0);
    r0 = rd_log.size();
    port_op(0, 0, 32'h00C, 4'hF, 32'h0, rd, lat);
    chk("after_reset_rdata", rd, 32'h0);
    chk("after_reset_refill", rd_log.size() - r0, 4);

    // random traffic against the flat memory model
    for (int i = 0; i < 1000; i++) begin
      isd = 1'($urandom_range(0, 1));
      we  = isd ? 1'($urandom_range(0, 1)) : 1'b0;
      a   = $urandom_range(0, 63) * 4;
      be  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      port_op(isd, we, a, be, wd, rd, lat);
      if (we) model_write(a, be, wd);
      else chk($sformatf("rnd%0d_%s_%h", i, isd ? "data" : "inst", a), rd, model[a[11:2]]);
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 64; k++) chk($sformatf("final_mem_%0d", k), mem[k], model[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
